// File: rtl/riscv_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch front end.
// Imported by the prefetch buffer, its queue, and the testbench.
package riscv_fetch_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam int unsigned PC_STEP  = 4;

  // Classification of an incoming memory response.
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_FILL,
    RSP_DROP,
    RSP_STRAY
  } rsp_kind_t;

  // Queue pointers carry one extra wrap bit so that full and empty can be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_prefetch_buffer_if.sv
// Fetch-side bundle: the instruction memory request/response channel plus
// the IF_ID presentation and redirect controls.
interface inst_prefetch_buffer_if #(
  parameter int XLEN = 32
);

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            if_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output if_valid,
    output if_pc,
    output if_inst,
    input  if_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  if_valid,
    input  if_pc,
    input  if_inst,
    output if_ready,
    output redirect,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular pc/instruction store with alloc, fill and head pointers.
// Slots are reserved at request accept and filled in order as responses arrive.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  localparam int PW   = riscv_fetch_pkg::ptr_w(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_inst,
  input  logic            pop,
  input  logic            flush,
  output logic [PW-1:0]   used,
  output logic [PW-1:0]   pending,
  output logic [PW-1:0]   filled,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_inst
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [PW-1:0]   alloc_ptr;
  logic [PW-1:0]   fill_ptr;
  logic [PW-1:0]   head_ptr;
  logic            full;
  logic            do_alloc;
  logic            do_fill;
  logic            do_pop;

  assign used    = alloc_ptr - head_ptr;
  assign pending = alloc_ptr - fill_ptr;
  assign filled  = fill_ptr - head_ptr;
  assign full    = (used == PW'(DEPTH));

  // Each operation is guarded against its own underflow/overflow; a flush overrides all of them.
  assign do_alloc = alloc && !flush && !full;
  assign do_fill  = fill  && !flush && (pending != '0);
  assign do_pop   = pop   && !flush && (filled != '0);

  assign head_pc   = pc_mem[head_ptr[AW-1:0]];
  assign head_inst = inst_mem[head_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
    end else if (flush) begin
      fill_ptr <= alloc_ptr;
      head_ptr <= alloc_ptr;
    end else begin
      if (do_alloc) alloc_ptr <= alloc_ptr + 1'b1;
      if (do_fill)  fill_ptr  <= fill_ptr + 1'b1;
      if (do_pop)   head_ptr  <= head_ptr + 1'b1;
    end
  end

  // Storage carries no reset: a slot is only read once its pointers mark it filled.
  always_ff @(posedge clk) begin
    if (do_alloc) pc_mem[alloc_ptr[AW-1:0]] <= alloc_pc;
    if (do_fill)  inst_mem[fill_ptr[AW-1:0]] <= fill_inst;
  end

  a_no_alloc_when_full : assert property (
    @(posedge clk) disable iff (!reset) (alloc && !flush) |-> !full
  ) else $error("fetch_queue: allocation attempted while full");

endmodule

// File: rtl/inst_prefetch_buffer.sv
// In-order instruction prefetch front end: issues sequential fetches, buffers the
// returned words with their PCs, and presents them to IF_ID with stall and redirect.
module inst_prefetch_buffer #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = riscv_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                    clk,
  input logic                    reset,
  inst_prefetch_buffer_if.master bus
);

  import riscv_fetch_pkg::*;

  localparam int PW = ptr_w(DEPTH);
  // Responses still owed from before a redirect can outnumber the queue, so the drop counter is wider.
  localparam int DW = PW + 2;

  logic [XLEN-1:0] fetch_pc;
  logic [DW-1:0]   drop_cnt;
  logic [DW-1:0]   drop_on_redirect;
  logic [DW:0]     drop_sum;
  logic [PW-1:0]   used;
  logic [PW-1:0]   pending;
  logic [PW-1:0]   filled;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_inst;
  logic            accept;
  logic            fill_en;
  logic            pop_en;
  rsp_kind_t       rsp_kind;

  assign bus.imem_req_valid = reset && !bus.redirect && (used < PW'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign accept             = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.if_valid = (filled != '0);
  assign bus.if_pc    = bus.if_valid ? head_pc : '0;
  assign bus.if_inst  = bus.if_valid ? head_inst : XLEN'(INST_NOP);

  assign pop_en  = bus.if_valid && bus.if_ready && !bus.redirect;
  assign fill_en = (rsp_kind == RSP_FILL) && !bus.redirect;

  // Responses first pay off words owed to a flushed stream before filling live slots.
  always_comb begin
    rsp_kind = RSP_NONE;
    if (bus.imem_rsp_valid) begin
      if (drop_cnt != '0)     rsp_kind = RSP_DROP;
      else if (pending != '0) rsp_kind = RSP_FILL;
      else                    rsp_kind = RSP_STRAY;
    end
  end

  // On redirect every in-flight request becomes debt; a response arriving in that same cycle pays one off.
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + (DW+1)'(pending);
    if (bus.imem_rsp_valid && (drop_sum != '0)) drop_sum = drop_sum - 1'b1;
    drop_on_redirect = drop_sum[DW] ? '1 : drop_sum[DW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_pc & ~XLEN'(3);
      drop_cnt <= drop_on_redirect;
    end else begin
      if (accept)               fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      if (rsp_kind == RSP_DROP) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .alloc     (accept),
    .alloc_pc  (fetch_pc),
    .fill      (fill_en),
    .fill_inst (bus.imem_rsp_data),
    .pop       (pop_en),
    .flush     (bus.redirect),
    .used      (used),
    .pending   (pending),
    .filled    (filled),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  a_no_stray_response : assert property (
    @(posedge clk) disable iff (!reset) bus.imem_rsp_valid |-> (rsp_kind != RSP_STRAY)
  ) else $error("inst_prefetch_buffer: response with nothing outstanding");

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: directed scenarios plus randomized traffic,
// compared against a queue/epoch model of the fetch stream and a hashed memory image.
module tb_inst_prefetch_buffer;

  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    bit          filled;
  } slot_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  inst_prefetch_buffer_if #(.XLEN(32)) bus ();

  inst_prefetch_buffer #(
    .DEPTH    (DEPTH),
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc;
  int          epoch = 0;
  int          ready_pct;
  int          lat_min;
  int          lat_max;
  slot_t       slot_q[$];
  mreq_t       mem_q[$];
  logic [31:0] model_pc;
  logic [31:0] next_pop_pc;
  logic [31:0] first_pop_pc;
  bit          first_pop_seen;
  int          first_accept_cyc;
  int          first_valid_cyc;
  int          accept_count;

  // Memory image: every address holds a distinct hashed word.
  function automatic logic [31:0] img(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%h expected=%h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // One clock cycle: drive inputs and memory, check outputs, advance the model, step the clock.
  task automatic applyStimulus(input bit ifr, input bit redir, input logic [31:0] rpc);
    bit    exp_req;
    bit    exp_if;
    bit    rsp;
    bit    accept;
    bit    placed;
    mreq_t r;
    int    lat;
    bus.if_ready       = ifr;
    bus.redirect       = redir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    rsp                = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? img(mem_q[0].addr) : $urandom();
    #1;
    exp_req = !redir && (slot_q.size() < DEPTH);
    exp_if  = (slot_q.size() > 0) && slot_q[0].filled;
    checkOutput("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
    if (exp_req) checkOutput("req_addr", bus.imem_req_addr, model_pc);
    checkOutput("if_valid", 32'(bus.if_valid), 32'(exp_if));
    if (exp_if) begin
      checkOutput("if_pc", bus.if_pc, slot_q[0].pc);
      checkOutput("if_inst", bus.if_inst, img(slot_q[0].pc));
    end else begin
      checkOutput("if_pc_idle", bus.if_pc, 32'h0);
      checkOutput("if_inst_nop", bus.if_inst, INST_NOP);
    end
    if (bus.imem_req_valid === 1'b1 && bus.imem_req_ready) begin
      accept_count++;
      if (first_accept_cyc < 0) first_accept_cyc = cyc;
    end
    if (bus.if_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    accept = exp_req && bus.imem_req_ready;
    if (rsp) r = mem_q.pop_front();
    if (redir) begin
      slot_q.delete();
      epoch++;
      model_pc       = rpc & ~32'h3;
      next_pop_pc    = model_pc;
      first_pop_seen = 1'b0;
    end else begin
      if (exp_if && ifr) begin
        checkOutput("pop_sequence", bus.if_pc, next_pop_pc);
        if (!first_pop_seen) begin
          first_pop_seen = 1'b1;
          first_pop_pc   = bus.if_pc;
        end
        next_pop_pc += 32'd4;
        void'(slot_q.pop_front());
      end
      if (rsp && r.epoch == epoch) begin
        placed = 1'b0;
        foreach (slot_q[i]) begin
          if (!placed && !slot_q[i].filled) begin
            slot_q[i].filled = 1'b1;
            placed = 1'b1;
          end
        end
      end
      if (accept) begin
        lat = $urandom_range(lat_max, lat_min);
        mem_q.push_back('{model_pc, cyc + lat, epoch});
        slot_q.push_back('{model_pc, 1'b0});
        model_pc += 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear before any clock edge. Memory is reset too.
  task automatic resetDut();
    @(negedge clk);
    #2;
    reset              = 1'b0;
    bus.redirect       = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #1;
    checkOutput("reset_req_valid", 32'(bus.imem_req_valid), 32'h0);
    checkOutput("reset_if_valid", 32'(bus.if_valid), 32'h0);
    checkOutput("reset_if_pc", bus.if_pc, 32'h0);
    checkOutput("reset_if_inst", bus.if_inst, INST_NOP);
    mem_q.delete();
    slot_q.delete();
    epoch++;
    model_pc         = 32'h0;
    next_pop_pc      = 32'h0;
    first_pop_seen   = 1'b0;
    first_pop_pc     = 32'hFFFF_FFFF;
    first_accept_cyc = -1;
    first_valid_cyc  = -1;
    accept_count     = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    bus.if_ready       = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    cyc                = 0;

    // Streaming fetch with single-cycle memory
    ready_pct = 100; lat_min = 1; lat_max = 1;
    resetDut();
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t1_first_accept_cyc", 32'(first_accept_cyc), 32'd0);
    checkOutput("t1_accept_to_valid", 32'(first_valid_cyc - first_accept_cyc), 32'd2);

    // Hazard stall fills the queue and throttles requests
    resetDut();
    repeat (10) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("t2_accepts", 32'(accept_count), 32'd4);
    checkOutput("t2_if_pc_held", bus.if_pc, 32'h0);
    checkOutput("t2_req_valid_low", 32'(bus.imem_req_valid), 32'h0);
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);

    // Redirect with three requests outstanding
    lat_min = 6; lat_max = 6;
    resetDut();
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0103);
    repeat (20) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t3_first_pop_seen", 32'(first_pop_seen), 32'd1);
    checkOutput("t3_first_pop_pc", first_pop_pc, 32'h0000_0100);

    // Redirect coinciding with a response and a pop
    lat_min = 3; lat_max = 3;
    resetDut();
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200);
    checkOutput("t4_if_valid_after", 32'(bus.if_valid), 32'h0);
    repeat (12) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t4_first_pop_pc", first_pop_pc, 32'h0000_0200);

    // Randomized backpressure, latency, stalls and occasional redirects
    ready_pct = 60; lat_min = 1; lat_max = 5;
    resetDut();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(3) != 0), ($urandom_range(39) == 0), $urandom());
    end
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF4);
    repeat (40) applyStimulus(($urandom_range(3) != 0), 1'b0, 32'h0);

    // Reset while two requests are still outstanding
    ready_pct = 100; lat_min = 5; lat_max = 5;
    resetDut();
    repeat (2) applyStimulus(1'b1, 1'b0, 32'h0);
    lat_min = 1; lat_max = 1;
    resetDut();
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("t6_first_accept_cyc", 32'(first_accept_cyc), 32'd0);
    checkOutput("t6_first_pop_pc", first_pop_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
